// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
// Holds FSM state encoding, opcode values, ALU/mux select codes and the
// packed control vector handed from the decode sub-module to the top.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_R_EX     = 4'd3,
    S_R_WB     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ORI_EX   = 4'd11,
    S_ORI_WB   = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  // ALU operand A select
  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_RS = 1'b1;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full datapath control vector, one field per output port
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_wr;
    logic       pc_wr;
    logic       pc_wr_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] alu_op;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  // States that hold mem_req and therefore wait on mem_ack
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_out.sv
// Control decode: maps the FSM state to the datapath control vector.
// Latency: purely combinational, same cycle as the state register.
// Backpressure: none; only FETCH looks at mem_ack to gate IR/PC writes.
module multicycle_ctrl_out
  import ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ack,
  output ctrl_t  ctl
);

  // Per-state Moore decode; every field defaults low so IDLE/HALT drive zeros
  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.iord      = 1'b0;
        ctl.alu_src_a = SRCA_PC;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_src    = PCSRC_ALU;
        // IR load and PC+4 commit only on the completing beat
        ctl.ir_wr     = mem_ack;
        ctl.pc_wr     = mem_ack;
      end
      S_DECODE: begin
        ctl.alu_src_a = SRCA_PC;
        ctl.alu_src_b = SRCB_BR;
        ctl.alu_op    = ALU_ADD;
      end
      S_R_EX: begin
        ctl.alu_src_a = SRCA_RS;
        ctl.alu_src_b = SRCB_RT;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctl.reg_wr     = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.mem_to_reg = 1'b0;
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = SRCA_RS;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        ctl.mem_we  = 1'b0;
      end
      S_MEM_WB: begin
        ctl.reg_wr     = 1'b1;
        ctl.reg_dst    = 1'b0;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        ctl.mem_we  = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a  = SRCA_RS;
        ctl.alu_src_b  = SRCB_RT;
        ctl.alu_op     = ALU_SUB;
        ctl.pc_wr_cond = 1'b1;
        ctl.pc_src     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctl.pc_wr  = 1'b1;
        ctl.pc_src = PCSRC_JUMP;
      end
      S_ORI_EX: begin
        ctl.alu_src_a = SRCA_RS;
        ctl.alu_src_b = SRCB_IMM;
        ctl.ext_zero  = 1'b1;
        ctl.alu_op    = ALU_OR;
      end
      S_ORI_WB: begin
        ctl.reg_wr     = 1'b1;
        ctl.reg_dst    = 1'b0;
        ctl.mem_to_reg = 1'b0;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset controller: FSM, memory timeout and retire counter.
// Latency: BEQ/J 3, R/SW/ORI 4, LW 5 cycles FETCH-to-FETCH with single-cycle ack.
// Backpressure: FETCH/MEM_RD/MEM_WR hold mem_req until mem_ack; TMO_CYC unacked waits halt.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RET_W   = 32,
  parameter int TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             pc_wr_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [1:0]       alu_op,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [RET_W-1:0] retired
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_last;
  logic             tmo_hit;
  logic             bad_op;
  logic             retire;
  ctrl_t            ctl;

  // The BEQ zero flag is qualified by pc_wr_cond inside the datapath, so the
  // controller itself never needs it.
  logic unused_zero;
  assign unused_zero = zero;

  // This wait cycle is the last one allowed before declaring a bus error
  assign tmo_last = (tmo_cnt == TMO_W'(TMO_CYC - 1));

  // Next-state selection plus timeout/illegal/retire event flags
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    bad_op    = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          state_nxt = S_DECODE;
        end else if (tmo_last) begin
          state_nxt = S_HALT;
          tmo_hit   = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = S_R_EX;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ORI:       state_nxt = S_ORI_EX;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            state_nxt = S_HALT;
            bad_op    = 1'b1;
          end
        endcase
      end
      S_R_EX:     state_nxt = S_R_WB;
      S_R_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEM_ADDR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ack) begin
          state_nxt = S_MEM_WB;
        end else if (tmo_last) begin
          state_nxt = S_HALT;
          tmo_hit   = 1'b1;
        end
      end
      S_MEM_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ack) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else if (tmo_last) begin
          state_nxt = S_HALT;
          tmo_hit   = 1'b1;
        end
      end
      S_BRANCH, S_JUMP, S_ORI_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_ORI_EX:   state_nxt = S_ORI_WB;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait counter: counts unacked cycles while parked in a request state,
  // cleared whenever a request state is entered or left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (is_mem_state(state) && (state_nxt == state)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Sticky halt-cause flags; only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if (bad_op)  illegal_op <= 1'b1;
      if (tmo_hit) bus_err    <= 1'b1;
    end
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + RET_W'(1);
    end
  end

  multicycle_ctrl_out u_out (
    .state   (state),
    .mem_ack (mem_ack),
    .ctl     (ctl)
  );

  assign halted     = (state == S_HALT);
  assign mem_req    = ctl.mem_req;
  assign mem_we     = ctl.mem_we;
  assign iord       = ctl.iord;
  assign ir_wr      = ctl.ir_wr;
  assign pc_wr      = ctl.pc_wr;
  assign pc_wr_cond = ctl.pc_wr_cond;
  assign pc_src     = ctl.pc_src;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign ext_zero   = ctl.ext_zero;
  assign alu_op     = ctl.alu_op;
  assign reg_wr     = ctl.reg_wr;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces, a
// directed table, hand-built corner sequences and randomized instructions.
// Memory latency is chosen by the bench; the DUT is never read for expectations.
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, iord, ir_wr, pc_wr, pc_wr_cond;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        alu_src_a, ext_zero, reg_wr, reg_dst, mem_to_reg;
  logic        halted, illegal_op, bus_err;
  logic [31:0] retired;

  multicycle_ctrl #(.RET_W(32), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .pc_wr_cond(pc_wr_cond), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_op(alu_op), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halted(halted),
    .illegal_op(illegal_op), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  // Observed control vector in a fixed field order
  logic [16:0] act_ctl;
  assign act_ctl = {mem_req, mem_we, iord, ir_wr, pc_wr, pc_wr_cond, pc_src,
                    alu_src_a, alu_src_b, ext_zero, alu_op, reg_wr, reg_dst, mem_to_reg};
  logic [2:0] act_flg;
  assign act_flg = {halted, illegal_op, bus_err};

  typedef struct packed {
    logic        ack;
    logic [5:0]  opc;
    logic        zero;
    logic [16:0] ctl;
    logic [2:0]  flg;
    logic        ret;
  } step_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          step_no = 0;
  int unsigned exp_ret = 0;
  step_t       q[$];
  logic [5:0]  cur_opc;
  logic        cur_zero;

  logic [16:0] V_ZERO, V_FW, V_FA, V_DEC, V_REX, V_RWB, V_MA, V_MRD, V_MWB, V_MWR;
  logic [16:0] V_BR, V_JMP, V_OEX, V_OWB;
  localparam logic [2:0] F_NONE = 3'b000, F_ILL = 3'b110, F_BUS = 3'b101;
  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
                         O_BEQ = 6'b000100, O_ORI = 6'b001101, O_J = 6'b000010;

  function automatic logic [16:0] cv(
      input logic req, we, io, irw, pcw, pcc, input logic [1:0] ps,
      input logic a, input logic [1:0] b, input logic ez, input logic [1:0] op,
      input logic rw, rd, m2r);
    return {req, we, io, irw, pcw, pcc, ps, a, b, ez, op, rw, rd, m2r};
  endfunction

  function automatic step_t mk(input logic ack, input logic [5:0] opc, input logic z,
                               input logic [16:0] c, input logic [2:0] f, input logic r);
    step_t s;
    s.ack = ack; s.opc = opc; s.zero = z; s.ctl = c; s.flg = f; s.ret = r;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", nm, step_no, act, exp);
    end
  endtask

  // Called just after a rising edge: drive inputs, sample mid-cycle, advance one clock
  task automatic apply_step(input step_t s);
    mem_ack = s.ack; opcode = s.opc; zero = s.zero;
    #1;
    chk("ctl", {15'd0, act_ctl}, {15'd0, s.ctl});
    chk("flags", {29'd0, act_flg}, {29'd0, s.flg});
    chk("retired", retired, exp_ret);
    @(posedge clk); #1;
    if (s.ret) exp_ret++;
    step_no++;
  endtask

  task automatic run_q();
    foreach (q[i]) apply_step(q[i]);
    q.delete();
  endtask

  // Non-request cycles get a random ack, which the DUT must ignore
  task automatic push(input logic [16:0] c, input logic [2:0] f, input logic r);
    q.push_back(mk(1'($urandom % 2), cur_opc, cur_zero, c, f, r));
  endtask

  // Memory phase: d idle-ack cycles, then the ack cycle; d >= TMO means a timeout
  task automatic mem_phase(input int d, input logic [16:0] wv, input logic [16:0] av,
                           input logic r, output logic to);
    to = 1'b0;
    if (d >= TMO) begin
      for (int i = 0; i < TMO; i++) q.push_back(mk(1'b0, cur_opc, cur_zero, wv, F_NONE, 1'b0));
      to = 1'b1;
    end else begin
      for (int i = 0; i < d; i++) q.push_back(mk(1'b0, cur_opc, cur_zero, wv, F_NONE, 1'b0));
      q.push_back(mk(1'b1, cur_opc, cur_zero, av, F_NONE, r));
    end
  endtask

  // Expected cycle trace of one instruction; hk = 0 ok, 1 illegal, 2 bus error
  task automatic build_instr(input logic [5:0] opc, input logic z, input int df,
                             input int dm, output int hk);
    logic to;
    cur_opc = opc; cur_zero = z; hk = 0;
    mem_phase(df, V_FW, V_FA, 1'b0, to);
    if (to) begin hk = 2; return; end
    push(V_DEC, F_NONE, 1'b0);
    case (opc)
      O_R:   begin push(V_REX, F_NONE, 1'b0); push(V_RWB, F_NONE, 1'b1); end
      O_LW: begin
        push(V_MA, F_NONE, 1'b0);
        mem_phase(dm, V_MRD, V_MRD, 1'b0, to);
        if (to) hk = 2; else push(V_MWB, F_NONE, 1'b1);
      end
      O_SW: begin
        push(V_MA, F_NONE, 1'b0);
        mem_phase(dm, V_MWR, V_MWR, 1'b1, to);
        if (to) hk = 2;
      end
      O_BEQ: push(V_BR, F_NONE, 1'b1);
      O_J:   push(V_JMP, F_NONE, 1'b1);
      O_ORI: begin push(V_OEX, F_NONE, 1'b0); push(V_OWB, F_NONE, 1'b1); end
      default: hk = 1;
    endcase
  endtask

  task automatic push_halt(input int n, input int hk);
    for (int i = 0; i < n; i++) push(V_ZERO, (hk == 1) ? F_ILL : F_BUS, 1'b0);
  endtask

  // Reset from any point: outputs must drop immediately, then IDLE is observed
  task automatic do_reset();
    rst_n = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rst_ctl", {15'd0, act_ctl}, 32'd0);
    chk("rst_flags", {29'd0, act_flg}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; exp_ret = 0;
    push(V_ZERO, F_NONE, 1'b0);
    run_q();
  endtask

  task automatic seq(input logic [5:0] opc, input logic z, input int df, input int dm,
                     input int nhalt);
    int hk;
    build_instr(opc, z, df, dm, hk);
    if (hk != 0) push_halt(nhalt, hk);
    run_q();
    if (hk != 0) do_reset();
  endtask

  step_t tbl [5];

  initial begin
    int hk;
    logic [5:0] legal [6];
    logic [5:0] ro;

    V_ZERO = '0;
    V_FW  = cv(1,0,0,0,0,0,2'b00,0,2'b01,0,2'b00,0,0,0);
    V_FA  = cv(1,0,0,1,1,0,2'b00,0,2'b01,0,2'b00,0,0,0);
    V_DEC = cv(0,0,0,0,0,0,2'b00,0,2'b11,0,2'b00,0,0,0);
    V_REX = cv(0,0,0,0,0,0,2'b00,1,2'b00,0,2'b10,0,0,0);
    V_RWB = cv(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,1,0);
    V_MA  = cv(0,0,0,0,0,0,2'b00,1,2'b10,0,2'b00,0,0,0);
    V_MRD = cv(1,0,1,0,0,0,2'b00,0,2'b00,0,2'b00,0,0,0);
    V_MWB = cv(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,0,1);
    V_MWR = cv(1,1,1,0,0,0,2'b00,0,2'b00,0,2'b00,0,0,0);
    V_BR  = cv(0,0,0,0,0,1,2'b01,1,2'b00,0,2'b01,0,0,0);
    V_JMP = cv(0,0,0,0,1,0,2'b10,0,2'b00,0,2'b00,0,0,0);
    V_OEX = cv(0,0,0,0,0,0,2'b00,1,2'b10,1,2'b11,0,0,0);
    V_OWB = cv(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,0,0);
    legal[0] = O_R; legal[1] = O_LW; legal[2] = O_SW;
    legal[3] = O_BEQ; legal[4] = O_ORI; legal[5] = O_J;

    // Directed table: reset, IDLE, then one R-type add with single-cycle ack
    tbl[0] = mk(1'b1, O_R, 1'b0, V_ZERO, F_NONE, 1'b0);
    tbl[1] = mk(1'b1, O_R, 1'b0, V_FA,   F_NONE, 1'b0);
    tbl[2] = mk(1'b0, O_R, 1'b0, V_DEC,  F_NONE, 1'b0);
    tbl[3] = mk(1'b1, O_R, 1'b0, V_REX,  F_NONE, 1'b0);
    tbl[4] = mk(1'b0, O_R, 1'b0, V_RWB,  F_NONE, 1'b1);

    rst_n = 1'b0; mem_ack = 1'b0; opcode = '0; zero = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rst_ctl", {15'd0, act_ctl}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) apply_step(tbl[i]);

    // LW with the read ack arriving on the 4th MEM_RD cycle
    seq(O_LW, 1'b0, 0, 3, 0);
    // BEQ taken and not taken: identical controls, both retire
    seq(O_BEQ, 1'b1, 0, 0, 0);
    seq(O_BEQ, 1'b0, 0, 0, 0);
    seq(O_SW, 1'b0, 1, 2, 0);
    seq(O_ORI, 1'b0, 2, 0, 0);
    seq(O_J, 1'b0, 0, 0, 0);

    // Reset asserted mid MEM_WR with retired non-zero
    cur_opc = O_SW; cur_zero = 1'b0;
    build_instr(O_SW, 1'b0, 0, 9, hk);
    q = q[0:2];
    run_q();
    mem_ack = 1'b0; opcode = O_SW;
    #1;
    chk("mid_wr_req", {31'd0, mem_req}, 32'd1);
    chk("mid_wr_ret_nonzero", {31'd0, (retired != 0)}, 32'd1);
    do_reset();
    cur_opc = O_R;
    q.push_back(mk(1'b0, O_R, 1'b0, V_FW, F_NONE, 1'b0));
    run_q();
    q.push_back(mk(1'b1, O_R, 1'b0, V_FA, F_NONE, 1'b0));
    push(V_DEC, F_NONE, 1'b0); push(V_REX, F_NONE, 1'b0); push(V_RWB, F_NONE, 1'b1);
    run_q();

    // Illegal opcode: HALT persists for 20 cycles
    seq(6'b111111, 1'b0, 0, 0, 20);
    // Fetch never acked: bus error after TMO waits
    seq(O_R, 1'b0, TMO, 0, 3);
    // Ack on the last permitted wait cycle wins
    seq(O_R, 1'b0, TMO - 1, 0, 0);
    // Read timeout in MEM_RD
    seq(O_LW, 1'b0, 0, TMO + 2, 3);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      int df, dm, nh;
      if ($urandom_range(0, 15) == 0) begin
        ro = 6'($urandom);
        if (ro inside {O_R, O_LW, O_SW, O_BEQ, O_ORI, O_J}) ro = 6'b111111;
      end else begin
        ro = legal[$urandom_range(0, 5)];
      end
      df = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, TMO - 1);
      dm = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, TMO - 1);
      nh = $urandom_range(1, 5);
      seq(ro, 1'($urandom % 2), df, dm, nh);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
